down_counter16_timer: RTL and testbench
=======================================

Name: down_counter16_timer

Overview:
- Synchronous, loadable down-counter timer. It is the counting-down counterpart to the team's 16-bit ripple up-counter.
- Software or a controller loads a start value. The block decrements it once per clock while run is high.
- When the count reaches zero it raises a one-cycle terminal-count pulse and a sticky expired flag.
- Used as a delay/timeout generator next to the event counters in the datapath.

Parameters:
WIDTH, 16, counter width in bits (legal range 2..32)

Ports:
clk  input  1  system clock; all state changes on posedge clk
rst  input  1  asynchronous, active-high reset; takes effect on posedge rst, independent of clk
load  input  1  when high at a clk edge, count register takes load_val
load_val  input  WIDTH  start value; also latched as the reload value
run  input  1  count enable; decrement allowed while high
d  output  WIDTH  current count value (registered)
tc  output  1  terminal-count pulse, high for exactly one cycle
expired  output  1  sticky flag set with tc, cleared by load
busy  output  1  high while state is COUNT

Behaviour:
- Reset (async, posedge rst):
  - d = 0, tc = 0, expired = 0, busy = 0.
  - Reload register = 0, state = IDLE.
  - rst held high overrides every other input.
- States (registered, 2 bits): IDLE, ARMED, COUNT, EXPIRED.
- Priority at each clk edge: load > decrement > hold.
- load = 1:
  - d <= load_val and reload register <= load_val; expired <= 0; tc <= 0.
  - Next state:
    - load_val == 0 -> IDLE.
    - load_val != 0 and run == 1 -> COUNT.
    - load_val != 0 and run == 0 -> ARMED.
  - The load cycle itself never decrements.
- Decrement: load = 0, run = 1, d != 0 -> d <= d - 1; state COUNT.
- Terminal count:
  - Trigger: decrement with d == 1.
  - Effects: d <= 0; tc <= 1 for the next cycle only; expired <= 1; state EXPIRED.
  - Latency: loading N (N ≥ 1) with run held high gives tc high in the cycle where d == 0, which is N edges after the load edge.
- run = 0 with d != 0 -> d holds; state ARMED (pause). Re-asserting run resumes from the held value, with no lost or extra count.
- d == 0 and load = 0 -> d holds at 0 regardless of run; no wrap to all-ones; tc stays 0.
- EXPIRED persists until load; IDLE is entered only via reset or load of 0.
- busy = (state == COUNT); it is a registered output.
- Simultaneous load and terminal count in the same cycle -> load wins; tc not asserted; expired cleared.
- Reset mid-count -> everything returns to reset values immediately; no tc is emitted.
- All arithmetic is unsigned modulo 2^WIDTH, but underflow is prevented by the zero hold.

Optional Feature:
- Macro: DOWN_COUNTER16_TIMER_RELOAD_EN.
- Defined:
  - At terminal count, d <= reload register instead of 0; tc pulses and expired sets as normal.
  - State stays COUNT while run = 1, giving a periodic tc every R cycles, where R = last loaded value.
  - If the reload register is 0, behaviour is identical to the feature being undefined.
- Undefined: one-shot behaviour as described in Behaviour; the reload register is still latched but unused.

Decomposition:
- Package timer_pkg holds:
  - State encodings: IDLE = 2'b00, ARMED = 2'b01, COUNT = 2'b10, EXPIRED = 2'b11.
  - Default width constant TIMER_WIDTH = 16.
- One sub-module, down_cnt_core: loadable WIDTH-bit register with decrement, zero-hold, and a "count == 1" detect. It has no FSM.
- The top level holds the FSM, tc/expired/busy registers and the reload register.

Test Plan:
- Reset during count: load 0x0005, run = 1, assert rst after 2 cycles -> d = 0, tc = 0, expired = 0, busy = 0 at once; stays so after rst falls.
- One-shot: load 0x0003 with run = 1 -> d sequence 3, 2, 1, 0; tc high only in the d = 0 cycle; expired = 1 and held; d stays 0 for 10 more cycles.
- Pause/resume: load 0x000A, run = 1 for 4 edges (d = 6), run = 0 for 5 edges (d = 6, state ARMED, busy = 0), run = 1 -> tc exactly 6 edges later.
- Load priority: at the edge where d = 1 and run = 1, assert load with 0x0004 -> d = 4, no tc, expired = 0.
- Zero/boundary:
  - load 0x0000 -> IDLE, no tc.
  - load 0xFFFF with run = 1 -> tc after 65535 edges, with no wrap afterwards.
- Reload (macro defined): load 0x0004 with run = 1 -> tc every 4 cycles; d sequence 4, 3, 2, 1, 4, 3, …; expired stays 1 until the next load.

Source files
------------

// File: rtl/down_counter16_timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared constants for the down_counter16_timer block.
//   TIMER_WIDTH : default counter width
//   ST_*        : 2-bit FSM state encodings (IDLE, ARMED, COUNT, EXPIRED)
//   load_state  : state entered on a load edge
// -----------------------------------------------------------------------------
package timer_pkg;

  localparam int TIMER_WIDTH = 16;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_ARMED   = 2'b01;
  localparam logic [1:0] ST_COUNT   = 2'b10;
  localparam logic [1:0] ST_EXPIRED = 2'b11;

  // A zero load parks the timer; a non-zero load either starts or arms it.
  function automatic logic [1:0] load_state(input logic val_is_zero, input logic run);
    logic [1:0] st;
    if (val_is_zero) begin
      st = ST_IDLE;
    end else if (run) begin
      st = ST_COUNT;
    end else begin
      st = ST_ARMED;
    end
    return st;
  endfunction

endpackage

// File: rtl/down_counter16_timer_if.sv
// -----------------------------------------------------------------------------
// down_counter16_timer_if
// Control/status bundle of the down-counter timer.
//   load, load_val, run : controller -> timer
//   d, tc, expired, busy: timer -> controller (all registered in the timer)
// Modports: master (controller side), slave (timer side).
// -----------------------------------------------------------------------------
interface down_counter16_timer_if #(
  parameter int WIDTH = 16
);

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             run;
  logic [WIDTH-1:0] d;
  logic             tc;
  logic             expired;
  logic             busy;

  modport master (
    output load, load_val, run,
    input  d, tc, expired, busy
  );

  modport slave (
    input  load, load_val, run,
    output d, tc, expired, busy
  );

endinterface

// File: rtl/down_counter16_timer_core.sv
// -----------------------------------------------------------------------------
// down_cnt_core
// Loadable WIDTH-bit down-counter register with zero hold.
//   clk, rst : clock, async active-high reset
//   ld       : load ld_val (highest priority)
//   ld_val   : value loaded when ld is high
//   dec      : decrement request; ignored while the count is zero
//   d        : registered count
//   is_one   : count == 1 (next decrement is the terminal one)
//   is_zero  : count == 0
// -----------------------------------------------------------------------------
module down_cnt_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             dec,
  output logic [WIDTH-1:0] d,
  output logic             is_one,
  output logic             is_zero
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] d_nxt;

  // Flags decoded from the current count.
  always_comb begin
    is_zero = (d == ZERO);
    is_one  = (d == ONE);
  end

  // Next count: load beats decrement; a zero count holds instead of wrapping.
  always_comb begin
    d_nxt = d;
    if (ld) begin
      d_nxt = ld_val;
    end else if (dec && !is_zero) begin
      d_nxt = d - ONE;
    end else begin
      d_nxt = d;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d <= ZERO;
    end else begin
      d <= d_nxt;
    end
  end

endmodule

// File: rtl/down_counter16_timer.sv
// -----------------------------------------------------------------------------
// down_counter16_timer
// Loadable down-counter timer: decrements once per clock while run is high,
// pulses tc for one cycle when the count reaches zero and sets a sticky
// expired flag that only a load clears.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : down_counter16_timer_if.slave (load, load_val, run / d, tc,
//         expired, busy)
// Optional build macro DOWN_COUNTER16_TIMER_RELOAD_EN: at terminal count the
// counter reloads the last loaded value instead of stopping at zero, giving a
// periodic tc. A reload value of zero behaves as one-shot.
// -----------------------------------------------------------------------------
module down_counter16_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  down_counter16_timer_if.slave bus
);

`ifdef DOWN_COUNTER16_TIMER_RELOAD_EN
  localparam logic RELOAD_EN = 1'b1;
`else
  localparam logic RELOAD_EN = 1'b0;
`endif

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] reload;
  logic             tc;
  logic             expired;
  logic             expired_nxt;
  logic             busy;

  logic [WIDTH-1:0] cnt;
  logic             cnt_is_one;
  logic             cnt_is_zero;
  logic             tc_hit;
  logic             wrap;
  logic             core_ld;
  logic [WIDTH-1:0] core_ld_val;

  // Terminal-count detect and the load/reload request to the counter core.
  // A load in the same cycle suppresses tc entirely.
  always_comb begin
    tc_hit      = !bus.load && bus.run && cnt_is_one;
    wrap        = RELOAD_EN && (reload != ZERO);
    core_ld     = bus.load || (tc_hit && wrap);
    core_ld_val = bus.load ? bus.load_val : reload;
  end

  down_cnt_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .ld      (core_ld),
    .ld_val  (core_ld_val),
    .dec     (bus.run),
    .d       (cnt),
    .is_one  (cnt_is_one),
    .is_zero (cnt_is_zero)
  );

  // FSM next state; a zero count keeps IDLE/EXPIRED until the next load.
  always_comb begin
    state_nxt = state;
    if (bus.load) begin
      state_nxt = load_state(bus.load_val == ZERO, bus.run);
    end else if (tc_hit) begin
      state_nxt = wrap ? ST_COUNT : ST_EXPIRED;
    end else if (!cnt_is_zero) begin
      state_nxt = bus.run ? ST_COUNT : ST_ARMED;
    end else begin
      state_nxt = state;
    end
  end

  // Sticky expired flag: load clears, terminal count sets.
  always_comb begin
    expired_nxt = expired;
    if (bus.load) begin
      expired_nxt = 1'b0;
    end else if (tc_hit) begin
      expired_nxt = 1'b1;
    end else begin
      expired_nxt = expired;
    end
  end

  // State, status registers and the reload register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      reload  <= ZERO;
      tc      <= 1'b0;
      expired <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      reload  <= bus.load ? bus.load_val : reload;
      tc      <= tc_hit;
      expired <= expired_nxt;
      busy    <= (state_nxt == ST_COUNT);
    end
  end

  assign bus.d       = cnt;
  assign bus.tc      = tc;
  assign bus.expired = expired;
  assign bus.busy    = busy;

endmodule

// File: tb/tb_down_counter16_timer.sv
// -----------------------------------------------------------------------------
// tb_down_counter16_timer
// Self-checking bench for down_counter16_timer (WIDTH = 16). A cycle-level
// reference model built from the timer's rules tracks count, tc, expired,
// busy and the reload value. Build with DOWN_COUNTER16_TIMER_RELOAD_EN to
// check the periodic-reload variant.
// -----------------------------------------------------------------------------
module tb_down_counter16_timer;

`ifdef DOWN_COUNTER16_TIMER_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  logic clk;
  logic rst;

  down_counter16_timer_if #(.WIDTH(16)) bus ();

  down_counter16_timer #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [15:0] m_d;
  logic [15:0] m_rel;
  bit          m_tc;
  bit          m_exp;
  bit          m_busy;

  task automatic model_reset();
    m_d = 16'd0; m_rel = 16'd0; m_tc = 1'b0; m_exp = 1'b0; m_busy = 1'b0;
  endtask

  // One clock edge of the timer's rules: load > decrement > hold.
  task automatic model_edge(input bit ld, input logic [15:0] v, input bit r);
    if (ld) begin
      m_d = v; m_rel = v; m_tc = 1'b0; m_exp = 1'b0;
      m_busy = (v != 16'd0) && r;
    end else if (r && m_d != 16'd0) begin
      if (m_d == 16'd1) begin
        m_tc  = 1'b1;
        m_exp = 1'b1;
        if (RELOAD && m_rel != 16'd0) begin
          m_d = m_rel; m_busy = 1'b1;
        end else begin
          m_d = 16'd0; m_busy = 1'b0;
        end
      end else begin
        m_d = m_d - 16'd1; m_tc = 1'b0; m_busy = 1'b1;
      end
    end else begin
      m_tc = 1'b0;
      if (m_d != 16'd0) m_busy = 1'b0;
    end
  endtask

  // Drive inputs (called just after a falling edge), clock once, return at the next falling edge.
  task automatic step(input bit ld, input logic [15:0] v, input bit r);
    bus.load = ld; bus.load_val = v; bus.run = r;
    @(posedge clk);
    model_edge(ld, v, r);
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    total++;
    if ({bus.d, bus.tc, bus.expired, bus.busy} !== {m_d, m_tc, m_exp, m_busy}) begin
      bad++;
      $display("FAIL reset_state: got d=%0d tc=%0b exp=%0b busy=%0b want all zero",
               bus.d, bus.tc, bus.expired, bus.busy);
    end
    rst = 1'b0;
    @(negedge clk);
    // load 5 with run, then reset mid-count between edges
    step(1'b1, 16'd5, 1'b1);
    step(1'b0, 16'd0, 1'b1);
    step(1'b0, 16'd0, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    total++;
    if ({bus.d, bus.tc, bus.expired, bus.busy} !== {m_d, m_tc, m_exp, m_busy}) begin
      bad++;
      $display("FAIL reset_async: got d=%0d tc=%0b exp=%0b busy=%0b want all zero",
               bus.d, bus.tc, bus.expired, bus.busy);
    end
    @(negedge clk);
    step(1'b1, 16'd9, 1'b1); // load ignored while rst is high
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'd0, 1'b1);
      total++;
      if ({bus.d, bus.tc, bus.expired, bus.busy} !== {m_d, m_tc, m_exp, m_busy}) begin
        bad++;
        $display("FAIL reset_after: got d=%0d tc=%0b exp=%0b busy=%0b want d=%0d tc=%0b exp=%0b busy=%0b",
                 bus.d, bus.tc, bus.expired, bus.busy, m_d, m_tc, m_exp, m_busy);
      end
    end
  endtask

  task automatic test_oneshot();
    int exp_d [4];
    exp_d = '{3, 2, 1, RELOAD ? 3 : 0};
    step(1'b1, 16'd3, 1'b1);
    for (int i = 0; i < 14; i++) begin
      if (i < 4) begin
        total++;
        if (bus.d !== exp_d[i][15:0] || bus.tc !== (i == 3)) begin
          bad++;
          $display("FAIL oneshot_seq[%0d]: got d=%0d tc=%0b want d=%0d tc=%0b",
                   i, bus.d, bus.tc, exp_d[i], (i == 3));
        end
      end
      total++;
      if ({bus.d, bus.tc, bus.expired, bus.busy} !== {m_d, m_tc, m_exp, m_busy}) begin
        bad++;
        $display("FAIL oneshot_model: got d=%0d tc=%0b exp=%0b busy=%0b want d=%0d tc=%0b exp=%0b busy=%0b",
                 bus.d, bus.tc, bus.expired, bus.busy, m_d, m_tc, m_exp, m_busy);
      end
      step(1'b0, 16'd0, 1'b1);
    end
  endtask

  task automatic test_pause_resume();
    int edges;
    step(1'b1, 16'd10, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 16'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 16'd0, 1'b0);
      total++;
      if (bus.d !== 16'd6 || bus.busy !== 1'b0 || bus.tc !== 1'b0) begin
        bad++;
        $display("FAIL pause_hold: got d=%0d busy=%0b tc=%0b want d=6 busy=0 tc=0",
                 bus.d, bus.busy, bus.tc);
      end
    end
    edges = 0;
    do begin
      step(1'b0, 16'd0, 1'b1);
      edges++;
    end while (bus.tc !== 1'b1 && edges < 20);
    total++;
    if (edges != 6) begin
      bad++;
      $display("FAIL resume_latency: got %0d edges want 6", edges);
    end
  endtask

  task automatic test_load_priority();
    step(1'b1, 16'd3, 1'b1);
    step(1'b0, 16'd0, 1'b1);
    step(1'b0, 16'd0, 1'b1); // d == 1 now
    step(1'b1, 16'd4, 1'b1);
    total++;
    if (bus.d !== 16'd4 || bus.tc !== 1'b0 || bus.expired !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL load_priority: got d=%0d tc=%0b exp=%0b busy=%0b want d=4 tc=0 exp=0 busy=1",
               bus.d, bus.tc, bus.expired, bus.busy);
    end
  endtask

  task automatic test_zero_boundary();
    int tc_edge;
    int tc_cnt;
    step(1'b1, 16'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.d !== 16'd0 || bus.tc !== 1'b0 || bus.busy !== 1'b0 || bus.expired !== 1'b0) begin
        bad++;
        $display("FAIL load_zero: got d=%0d tc=%0b busy=%0b exp=%0b want 0 0 0 0",
                 bus.d, bus.tc, bus.busy, bus.expired);
      end
      step(1'b0, 16'd0, 1'b1);
    end
    step(1'b1, 16'hFFFF, 1'b1);
    tc_edge = -1;
    tc_cnt  = 0;
    for (int i = 1; i <= 65540; i++) begin
      step(1'b0, 16'd0, 1'b1);
      if (bus.tc === 1'b1) begin
        tc_cnt++;
        if (tc_edge < 0) tc_edge = i;
      end
      total++;
      if ({bus.d, bus.tc, bus.expired, bus.busy} !== {m_d, m_tc, m_exp, m_busy}) begin
        bad++;
        $display("FAIL max_count[%0d]: got d=%0d tc=%0b exp=%0b busy=%0b want d=%0d tc=%0b exp=%0b busy=%0b",
                 i, bus.d, bus.tc, bus.expired, bus.busy, m_d, m_tc, m_exp, m_busy);
      end
    end
    total++;
    if (tc_edge != 65535 || tc_cnt != 1) begin
      bad++;
      $display("FAIL max_tc_edge: got edge=%0d pulses=%0d want edge=65535 pulses=1", tc_edge, tc_cnt);
    end
  endtask

`ifdef DOWN_COUNTER16_TIMER_RELOAD_EN
  task automatic test_reload();
    int exp_d [9];
    exp_d = '{4, 3, 2, 1, 4, 3, 2, 1, 4};
    step(1'b1, 16'd4, 1'b1);
    for (int i = 0; i < 9; i++) begin
      total++;
      if (bus.d !== exp_d[i][15:0] || bus.tc !== (i == 4 || i == 8) || bus.expired !== (i >= 4)) begin
        bad++;
        $display("FAIL reload_seq[%0d]: got d=%0d tc=%0b exp=%0b want d=%0d tc=%0b exp=%0b",
                 i, bus.d, bus.tc, bus.expired, exp_d[i], (i == 4 || i == 8), (i >= 4));
      end
      step(1'b0, 16'd0, 1'b1);
    end
  endtask
`endif

  task automatic test_random();
    bit          ld;
    bit          r;
    logic [15:0] v;
    for (int i = 0; i < 2000; i++) begin
      ld = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 3) != 0);
      v  = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12));
      step(ld, v, r);
      total++;
      if ({bus.d, bus.tc, bus.expired, bus.busy} !== {m_d, m_tc, m_exp, m_busy}) begin
        bad++;
        $display("FAIL random[%0d]: got d=%0d tc=%0b exp=%0b busy=%0b want d=%0d tc=%0b exp=%0b busy=%0b",
                 i, bus.d, bus.tc, bus.expired, bus.busy, m_d, m_tc, m_exp, m_busy);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.load = 1'b0; bus.load_val = 16'd0; bus.run = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_pause_resume();
    test_load_priority();
    test_zero_boundary();
`ifdef DOWN_COUNTER16_TIMER_RELOAD_EN
    test_reload();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
